// File: rtl/input_debouncer.sv
// Two-flop synchronizer followed by a counter-qualified level FSM.
// A level change is committed only after the synchronized input holds it for DEBOUNCE_CYCLES+1 edges.
module input_debouncer #(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned CNT_WIDTH       = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic in,
  output logic out,
  output logic busy,
  output logic glitch
);

  typedef enum logic [1:0] {IDLE_LO, CHK_HI, IDLE_HI, CHK_LO} state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

  logic                 sync0, sync1, in_s;
  state_t               state, state_next;
  logic [CNT_WIDTH-1:0] cnt, cnt_next;
  logic                 out_next, glitch_next;

  assign in_s = sync1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync0  <= 1'b0;
      sync1  <= 1'b0;
      state  <= IDLE_LO;
      cnt    <= '0;
      out    <= 1'b0;
      glitch <= 1'b0;
    end else begin
      sync0  <= in;
      sync1  <= sync0;
      state  <= state_next;
      cnt    <= cnt_next;
      out    <= out_next;
      glitch <= glitch_next;
    end
  end

  // The commit test (cnt == N-1) is checked before incrementing, so cnt never wraps.
  always_comb begin
    state_next  = state;
    cnt_next    = cnt;
    out_next    = out;
    glitch_next = 1'b0;
    case (state)
      IDLE_LO: begin
        if (in_s) begin
          state_next = CHK_HI;
          cnt_next   = '0;
        end
      end
      CHK_HI: begin
        if (!in_s) begin
          state_next  = IDLE_LO;
          cnt_next    = '0;
          glitch_next = 1'b1;
        end else if (cnt == CNT_LAST) begin
          state_next = IDLE_HI;
          out_next   = 1'b1;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + CNT_WIDTH'(1);
        end
      end
      IDLE_HI: begin
        if (!in_s) begin
          state_next = CHK_LO;
          cnt_next   = '0;
        end
      end
      CHK_LO: begin
        if (in_s) begin
          state_next  = IDLE_HI;
          cnt_next    = '0;
          glitch_next = 1'b1;
        end else if (cnt == CNT_LAST) begin
          state_next = IDLE_LO;
          out_next   = 1'b0;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + CNT_WIDTH'(1);
        end
      end
      default: begin
        state_next = IDLE_LO;
        cnt_next   = '0;
      end
    endcase
  end

  assign busy = (state == CHK_HI) || (state == CHK_LO);

endmodule

// File: tb/tb_input_debouncer.sv
// Scoreboard bench for input_debouncer (N=4, CNT_WIDTH=3): the driver queues expected
// output-change events {cycle, out, busy, glitch}; the monitor pops one per observed change.
module tb_input_debouncer;

  typedef struct {
    int   cyc;
    logic o;
    logic b;
    logic g;
  } ev_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic in    = 1'b1;
  logic out, busy, glitch;

  int   cyc      = 0;
  int   n_checks = 0;
  int   n_fails  = 0;
  ev_t  exp_q[$];
  logic [2:0] prev = 3'b000;

  input_debouncer #(.DEBOUNCE_CYCLES(4), .CNT_WIDTH(3)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .in     (in),
    .out    (out),
    .busy   (busy),
    .glitch (glitch)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every change of {out,busy,glitch}, sampled mid-cycle, must match the next queued event.
  always @(negedge clk) begin
    logic [2:0] cur;
    ev_t        e;
    cur = {out, busy, glitch};
    if (cur !== prev) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fails++;
        $display("FAIL unexpected_change: cyc=%0d out/busy/glitch=%b, required no change (was %b)",
                 cyc, cur, prev);
      end else begin
        e = exp_q.pop_front();
        if (e.cyc != cyc || cur !== {e.o, e.b, e.g}) begin
          n_fails++;
          $display("FAIL event: got cyc=%0d out/busy/glitch=%b, required cyc=%0d out/busy/glitch=%b%b%b",
                   cyc, cur, e.cyc, e.o, e.b, e.g);
        end
      end
    end
    prev = cur;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input int c, input logic o, input logic b, input logic g);
    ev_t e;
    e.cyc = c;
    e.o   = o;
    e.b   = b;
    e.g   = g;
    exp_q.push_back(e);
  endtask

  initial begin
    int e0;
    int f0;

    // Reset held with in=1: outputs must stay 0; after release, in=1 qualifies as a rise.
    step(5);
    rst_n = 1'b1;
    e0 = cyc;
    push(e0 + 3, 1'b0, 1'b1, 1'b0);
    push(e0 + 7, 1'b1, 1'b0, 1'b0);
    step(10);

    // Clean fall, rise, fall.
    e0 = cyc; in = 1'b0;
    push(e0 + 3, 1'b1, 1'b1, 1'b0);
    push(e0 + 7, 1'b0, 1'b0, 1'b0);
    step(10);
    e0 = cyc; in = 1'b1;
    push(e0 + 3, 1'b0, 1'b1, 1'b0);
    push(e0 + 7, 1'b1, 1'b0, 1'b0);
    step(10);
    e0 = cyc; in = 1'b0;
    push(e0 + 3, 1'b1, 1'b1, 1'b0);
    push(e0 + 7, 1'b0, 1'b0, 1'b0);
    step(10);

    // 5-cycle pulse qualifies, then its fall qualifies.
    e0 = cyc; in = 1'b1;
    push(e0 + 3,  1'b0, 1'b1, 1'b0);
    push(e0 + 7,  1'b1, 1'b0, 1'b0);
    push(e0 + 8,  1'b1, 1'b1, 1'b0);
    push(e0 + 12, 1'b0, 1'b0, 1'b0);
    step(5); in = 1'b0;
    step(12);

    // 4-cycle pulse aborts with a single glitch cycle.
    e0 = cyc; in = 1'b1;
    push(e0 + 3, 1'b0, 1'b1, 1'b0);
    push(e0 + 7, 1'b0, 1'b0, 1'b1);
    push(e0 + 8, 1'b0, 1'b0, 1'b0);
    step(4); in = 1'b0;
    step(10);

    // Bounce 1,0,1,0,1 then hold high.
    e0 = cyc;
    push(e0 + 3,  1'b0, 1'b1, 1'b0);
    push(e0 + 4,  1'b0, 1'b0, 1'b1);
    push(e0 + 5,  1'b0, 1'b1, 1'b0);
    push(e0 + 6,  1'b0, 1'b0, 1'b1);
    push(e0 + 7,  1'b0, 1'b1, 1'b0);
    push(e0 + 11, 1'b1, 1'b0, 1'b0);
    in = 1'b1; step(1);
    in = 1'b0; step(1);
    in = 1'b1; step(1);
    in = 1'b0; step(1);
    in = 1'b1; step(12);

    // Asynchronous reset in CHK_LO with cnt=2: outputs clear within the same cycle, no glitch.
    e0 = cyc; in = 1'b0;
    push(e0 + 3, 1'b1, 1'b1, 1'b0);
    push(e0 + 5, 1'b0, 1'b0, 1'b0);
    step(5);
    #2 rst_n = 1'b0;
    step(2);
    rst_n = 1'b1;
    step(10);

    // Re-establish high level, then a 2-cycle low pulse aborts on the low side.
    e0 = cyc; in = 1'b1;
    push(e0 + 3, 1'b0, 1'b1, 1'b0);
    push(e0 + 7, 1'b1, 1'b0, 1'b0);
    step(10);
    f0 = cyc; in = 1'b0;
    push(f0 + 3, 1'b1, 1'b1, 1'b0);
    push(f0 + 5, 1'b1, 1'b0, 1'b1);
    push(f0 + 6, 1'b1, 1'b0, 1'b0);
    step(2); in = 1'b1;
    step(10);

    n_checks++;
    if (exp_q.size() != 0) begin
      n_fails++;
      $display("FAIL pending_events: %0d expected events never observed, required 0 (next at cyc=%0d)",
               exp_q.size(), exp_q[0].cyc);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
